// File: rtl/sram_access_arbiter.sv
// Purpose: two-port arbiter sequencing SETUP/ACCESS/CAPTURE phases on a custom SRAM macro.
// Latency: gnt 1 cycle after acceptance, done/rdata 2+WAIT_CYCLES cycles after acceptance.
// Backpressure: requesters hold req until gnt; requests are only sampled in IDLE.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration (default is fixed priority, port 0 first).
module sram_access_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                owner, owner_nxt;
    logic                lat_we, lat_we_nxt;
    logic                csb_nxt, web_nxt;
    logic [ADDR_W-1:0]   sram_addr_nxt;
    logic [DATA_W-1:0]   sram_din_nxt;
    logic                gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, busy_nxt;
    logic [DATA_W-1:0]   rdata0_nxt, rdata1_nxt;
    logic                accept;
    logic                win;

    assign accept = (state == IDLE) && (req0 || req1);

`ifdef SRAM_ARB_RR_EN
    logic last_gnt;

    // On a tie the port not granted last wins; a lone requester always wins.
    assign win = (req0 && req1) ? ~last_gnt : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= 1'b1;
        else if (accept)
            last_gnt <= win;
    end
`else
    assign win = ~req0;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_nxt     = owner;
        lat_we_nxt    = lat_we;
        csb_nxt       = 1'b1;
        web_nxt       = 1'b1;
        sram_addr_nxt = sram_addr;
        sram_din_nxt  = sram_din;
        gnt0_nxt      = 1'b0;
        gnt1_nxt      = 1'b0;
        done0_nxt     = 1'b0;
        done1_nxt     = 1'b0;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = SETUP;
                    owner_nxt     = win;
                    lat_we_nxt    = win ? we1 : we0;
                    cnt_nxt       = 4'(WAIT_CYCLES);
                    csb_nxt       = 1'b0;
                    web_nxt       = win ? ~we1 : ~we0;
                    sram_addr_nxt = win ? addr1 : addr0;
                    sram_din_nxt  = win ? wdata1 : wdata0;
                    gnt0_nxt      = ~win;
                    gnt1_nxt      = win;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
                csb_nxt   = 1'b0;
                web_nxt   = ~lat_we;
            end
            ACCESS: begin
                if (cnt == 4'd1) begin
                    // Read data and done register together so the owner sees both in CAPTURE.
                    state_nxt = CAPTURE;
                    done0_nxt = ~owner;
                    done1_nxt = owner;
                    if (!lat_we) begin
                        if (owner)
                            rdata1_nxt = sram_dout;
                        else
                            rdata0_nxt = sram_dout;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    csb_nxt = 1'b0;
                    web_nxt = ~lat_we;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            sram_csb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_addr <= '0;
            sram_din  <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            owner     <= owner_nxt;
            lat_we    <= lat_we_nxt;
            sram_csb  <= csb_nxt;
            sram_web  <= web_nxt;
            sram_addr <= sram_addr_nxt;
            sram_din  <= sram_din_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            done0     <= done0_nxt;
            done1     <= done1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: vector table of single-port accesses
// plus hand sequences for contention, held request and mid-access reset.
module tb_sram_access_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int WAIT = 2;
    localparam int PER  = 3 + WAIT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, done0, gnt1, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          sram_csb, sram_web;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
    );

    // Behavioural macro: writes on any rising edge with csb/web low, read is asynchronous.
    logic [DW-1:0] mem [1<<AW];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) if (!sram_csb && !sram_web) mem[sram_addr] <= sram_din;
    assign sram_dout = mem[sram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd0;
        logic [DW-1:0] exp_rd1;
    } vec_t;

    vec_t vecs [8];

    // Caller is mid-cycle with the DUT idle; runs one access over 3+WAIT edges.
    task automatic do_access(input string tag, input logic port, input logic we,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        int gk, dk, csb_cnt, bus_err, other, busy_cnt;
        gk = 0; dk = 0; csb_cnt = 0; bus_err = 0; other = 0; busy_cnt = 0;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        for (int k = 1; k <= PER; k++) begin
            @(posedge clk); #1;
            if ((port ? gnt1 : gnt0) && gk == 0) begin
                gk = k;
                if (port) req1 = 1'b0; else req0 = 1'b0;
            end
            if ((port ? done1 : done0) && dk == 0) dk = k;
            if (port ? (gnt0 || done0) : (gnt1 || done1)) other++;
            if (busy) busy_cnt++;
            if (!sram_csb) begin
                csb_cnt++;
                if (sram_web !== ~we || sram_addr !== a || sram_din !== d) bus_err++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check({tag, " gnt_cycle"}, 64'(gk), 64'(1));
        check({tag, " done_cycle"}, 64'(dk), 64'(2 + WAIT));
        check({tag, " csb_low_cycles"}, 64'(csb_cnt), 64'(1 + WAIT));
        check({tag, " macro_bus_errors"}, 64'(bus_err), 64'(0));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(2 + WAIT));
        check({tag, " other_port_activity"}, 64'(other), 64'(0));
        check({tag, " rdata0"}, 64'(rdata0), 64'(e0));
        check({tag, " rdata1"}, 64'(rdata1), 64'(e1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0k, g1k, d0k, d1k, n_g0, n_g1, n_d1, last_g, gap_err;

        vecs[0] = '{1'b0, 1'b1, 5'd5,  8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 5'd3,  8'h3C, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 5'd31, 8'hFF, 8'hA5, 8'h3C};
        vecs[5] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF, 8'h3C};
        vecs[6] = '{1'b1, 1'b0, 5'd5,  8'h00, 8'hFF, 8'hA5};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 8'hA5};

        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #23;
        check("reset macro {csb,web,addr,din}", {sram_csb, sram_web, sram_addr, sram_din},
              {1'b1, 1'b1, 5'd0, 8'd0});
        check("reset {busy,gnt0,gnt1,done0,done1}", {busy, gnt0, gnt1, done0, done1}, 5'b0);
        check("reset {rdata0,rdata1}", {rdata0, rdata1}, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            do_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_rd0, vecs[i].exp_rd1);

        // Simultaneous requests: port 0 first, port 1 accepted in the IDLE after port 0 finishes.
        g0k = 0; g1k = 0; d0k = 0; d1k = 0; n_g0 = 0; n_g1 = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3; wdata1 = '0;
        for (int k = 1; k <= 2 * PER; k++) begin
            @(posedge clk); #1;
            if (gnt0) begin n_g0++; if (g0k == 0) g0k = k; req0 = 1'b0; end
            if (gnt1) begin n_g1++; if (g1k == 0) g1k = k; req1 = 1'b0; end
            if (done0 && d0k == 0) d0k = k;
            if (done1 && d1k == 0) d1k = k;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("both gnt0_cycle", 64'(g0k), 64'(1));
        check("both done0_cycle", 64'(d0k), 64'(2 + WAIT));
        check("both gnt1_cycle", 64'(g1k), 64'(4 + WAIT));
        check("both done1_cycle", 64'(d1k), 64'(5 + 2 * WAIT));
        check("both gnt counts {g0,g1}", {32'(n_g0), 32'(n_g1)}, {32'd1, 32'd1});
        check("both rdata {rd0,rd1}", {rdata0, rdata1}, {8'hA5, 8'h3C});

        // Port 1 holds a read request for 20 cycles: one grant per access period.
        n_g0 = 0; n_g1 = 0; n_d1 = 0; last_g = 0; gap_err = 0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3; wdata1 = '0;
        for (int k = 1; k <= 20 + PER; k++) begin
            @(posedge clk); #1;
            if (gnt0 || done0) n_g0++;
            if (gnt1) begin
                if (last_g != 0 && k - last_g != PER) gap_err++;
                last_g = k;
                n_g1++;
            end
            if (done1) n_d1++;
            if (k == 20) req1 = 1'b0;
        end
        check("held gnt1_count", 64'(n_g1), 64'((20 - 1) / PER + 1));
        check("held done1_count", 64'(n_d1), 64'((20 - 1) / PER + 1));
        check("held gnt_spacing_errors", 64'(gap_err), 64'(0));
        check("held port0_activity", 64'(n_g0), 64'(0));
        check("held rdata1", 64'(rdata1), 64'(8'h3C));

        // Reset pulsed while a write is in ACCESS.
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h11;
        @(posedge clk); #1;
        check("midrst gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst in access {busy,csb}", {busy, sram_csb}, 2'b10);
        rst_n = 1'b0;
        #2;
        check("midrst {csb,web,busy}", {sram_csb, sram_web, busy}, 3'b110);
        check("midrst {gnt0,gnt1,done0,done1}", {gnt0, gnt1, done0, done1}, 4'b0);
        check("midrst {rdata0,rdata1}", {rdata0, rdata1}, 16'h0);
        #2;
        rst_n = 1'b1;
        do_access("post_reset", 1'b0, 1'b0, 5'd5, 8'h00, 8'hA5, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
